// File: rtl/alsu_cmd_seq_if.sv
// Command and response channels between a command producer and alsu_cmd_seq.
// master drives commands and consumes responses; slave is the sequencer side.
interface alsu_cmd_seq_if #(
  parameter int CNT_W = 4
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_opcode;
  logic signed [2:0] cmd_A;
  logic signed [2:0] cmd_B;
  logic              cmd_cin;
  logic              cmd_serial_in;
  logic              cmd_direction;
  logic              cmd_red_op_A;
  logic              cmd_red_op_B;
  logic              cmd_bypass_A;
  logic              cmd_bypass_B;
  logic [CNT_W-1:0]  cmd_repeat;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [5:0]        rsp_out;
  logic              rsp_invalid;

  modport master (
    output cmd_valid, cmd_opcode, cmd_A, cmd_B, cmd_cin, cmd_serial_in,
           cmd_direction, cmd_red_op_A, cmd_red_op_B, cmd_bypass_A,
           cmd_bypass_B, cmd_repeat, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_out, rsp_invalid
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_A, cmd_B, cmd_cin, cmd_serial_in,
           cmd_direction, cmd_red_op_A, cmd_red_op_B, cmd_bypass_A,
           cmd_bypass_B, cmd_repeat, rsp_ready,
    output cmd_ready, rsp_valid, rsp_out, rsp_invalid
  );
endinterface

// File: rtl/alsu_cmd_seq.sv
// Buffers ALSU commands in a FIFO, drives each onto the ALSU bus for a
// programmable hold time, then samples the ALSU result and returns it.
module alsu_cmd_seq #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  alsu_cmd_seq_if.slave     bus,
  output logic signed [2:0] A,
  output logic signed [2:0] B,
  output logic [2:0]        opcode,
  output logic              cin,
  output logic              serial_in,
  output logic              direction,
  output logic              red_op_A,
  output logic              red_op_B,
  output logic              bypass_A,
  output logic              bypass_B,
  input  logic [5:0]        alsu_out,
  output logic              busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [2:0] opcode;
    logic [2:0] a;
    logic [2:0] b;
    logic       cin;
    logic       serial_in;
    logic       direction;
    logic       red_op_a;
    logic       red_op_b;
    logic       bypass_a;
    logic       bypass_b;
  } alsu_vec_t;

  typedef struct packed {
    alsu_vec_t        vec;
    logic [CNT_W-1:0] rep;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, RESP} state_t;

  state_t           state_q, state_d;
  cmd_t             mem [FIFO_DEPTH];
  cmd_t             in_cmd, head;
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic             full, empty, push, pop;
  alsu_vec_t        drive_q;
  logic [CNT_W-1:0] hold_q;
  logic             drain_q;
  logic             inv_pend;
  logic [5:0]       rsp_out_q;
  logic             rsp_inv_q;

  always_comb begin
    in_cmd               = '0;
    in_cmd.vec.opcode    = bus.cmd_opcode;
    in_cmd.vec.a         = bus.cmd_A;
    in_cmd.vec.b         = bus.cmd_B;
    in_cmd.vec.cin       = bus.cmd_cin;
    in_cmd.vec.serial_in = bus.cmd_serial_in;
    in_cmd.vec.direction = bus.cmd_direction;
    in_cmd.vec.red_op_a  = bus.cmd_red_op_A;
    in_cmd.vec.red_op_b  = bus.cmd_red_op_B;
    in_cmd.vec.bypass_a  = bus.cmd_bypass_A;
    in_cmd.vec.bypass_b  = bus.cmd_bypass_B;
    in_cmd.rep           = bus.cmd_repeat;
  end

  // Extra pointer bit distinguishes full from empty when indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign push  = bus.cmd_valid && !full;
  assign pop   = (state_q == IDLE) && !empty;
  assign head  = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= in_cmd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!empty) state_d = DRIVE;
      DRIVE: if (hold_q == CNT_W'(1)) state_d = DRAIN;
      DRAIN: if (drain_q) state_d = RESP;
      RESP:  if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drive_q   <= '0;
      hold_q    <= '0;
      drain_q   <= 1'b0;
      inv_pend  <= 1'b0;
      rsp_out_q <= '0;
      rsp_inv_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (!empty) begin
          drive_q  <= head.vec;
          hold_q   <= (head.rep == '0) ? CNT_W'(1) : head.rep;
          drain_q  <= 1'b0;
          inv_pend <= ((head.vec.red_op_a | head.vec.red_op_b) &
                       (head.vec.opcode[1] | head.vec.opcode[2])) |
                      (head.vec.opcode[1] & head.vec.opcode[2]);
        end
        DRIVE: begin
          hold_q <= hold_q - CNT_W'(1);
          if (hold_q == CNT_W'(1)) drive_q <= '0;
        end
        // ALSU registers its inputs, then its output: result valid 2 edges later.
        DRAIN: begin
          drain_q <= 1'b1;
          if (drain_q) begin
            rsp_out_q <= alsu_out;
            rsp_inv_q <= inv_pend;
          end
        end
        default: ;
      endcase
    end
  end

  assign A         = drive_q.a;
  assign B         = drive_q.b;
  assign opcode    = drive_q.opcode;
  assign cin       = drive_q.cin;
  assign serial_in = drive_q.serial_in;
  assign direction = drive_q.direction;
  assign red_op_A  = drive_q.red_op_a;
  assign red_op_B  = drive_q.red_op_b;
  assign bypass_A  = drive_q.bypass_a;
  assign bypass_B  = drive_q.bypass_b;

  assign bus.cmd_ready   = !full;
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_out     = rsp_out_q;
  assign bus.rsp_invalid = rsp_inv_q;
  assign busy            = (state_q != IDLE) || !empty;
endmodule

// File: tb/tb_alsu_cmd_seq.sv
// Directed bench for alsu_cmd_seq driving a behavioural two-stage ALSU model;
// all expected results are hand-computed constants.
module tb_alsu_cmd_seq;
  logic              clk;
  logic              rst;
  logic signed [2:0] A, B;
  logic [2:0]        opcode;
  logic              cin, serial_in, direction;
  logic              red_op_A, red_op_B, bypass_A, bypass_B;
  logic [5:0]        alsu_out;
  logic              busy;
  int                n_cmp;
  int                n_err;

  alsu_cmd_seq_if #(.CNT_W(4)) bus ();

  alsu_cmd_seq #(.FIFO_DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .A(A), .B(B), .opcode(opcode), .cin(cin), .serial_in(serial_in),
    .direction(direction), .red_op_A(red_op_A), .red_op_B(red_op_B),
    .bypass_A(bypass_A), .bypass_B(bypass_B),
    .alsu_out(alsu_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALSU model: input register stage, then output register stage.
  logic [2:0] r_op;
  logic [2:0] r_a, r_b;
  logic       r_cin, r_si, r_dir, r_ra, r_rb, r_ba, r_bb;
  logic [5:0] a6, b6, nxt;
  logic       r_inv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {r_op, r_a, r_b, r_cin, r_si, r_dir, r_ra, r_rb, r_ba, r_bb} <= '0;
      alsu_out <= '0;
    end else begin
      {r_op, r_a, r_b, r_cin, r_si, r_dir, r_ra, r_rb, r_ba, r_bb} <=
        {opcode, A, B, cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B};
      alsu_out <= nxt;
    end
  end

  always_comb begin
    a6    = {{3{r_a[2]}}, r_a};
    b6    = {{3{r_b[2]}}, r_b};
    r_inv = ((r_ra | r_rb) & (r_op[1] | r_op[2])) | (r_op[1] & r_op[2]);
    nxt   = '0;
    if (r_ba)       nxt = a6;
    else if (r_bb)  nxt = b6;
    else if (r_inv) nxt = '0;
    else begin
      case (r_op)
        3'd0: nxt = r_ra ? {5'b0, &r_a} : r_rb ? {5'b0, &r_b} : (a6 & b6);
        3'd1: nxt = r_ra ? {5'b0, ^r_a} : r_rb ? {5'b0, ^r_b} : (a6 ^ b6);
        3'd2: nxt = a6 + b6 + {5'b0, r_cin};
        3'd3: nxt = a6 * b6;
        3'd4: nxt = r_dir ? {alsu_out[4:0], r_si} : {r_si, alsu_out[5:1]};
        3'd5: nxt = r_dir ? {alsu_out[4:0], alsu_out[5]} : {alsu_out[0], alsu_out[5:1]};
        default: nxt = '0;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic drive_nz();
    return ({opcode, A, B, cin, serial_in, direction,
             red_op_A, red_op_B, bypass_A, bypass_B} != '0);
  endfunction

  task automatic set_cmd(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic c, input logic si, input logic dir,
                         input logic ra, input logic rb, input logic [3:0] rep);
    bus.cmd_opcode    = op;
    bus.cmd_A         = a;
    bus.cmd_B         = b;
    bus.cmd_cin       = c;
    bus.cmd_serial_in = si;
    bus.cmd_direction = dir;
    bus.cmd_red_op_A  = ra;
    bus.cmd_red_op_B  = rb;
    bus.cmd_bypass_A  = 1'b0;
    bus.cmd_bypass_B  = 1'b0;
    bus.cmd_repeat    = rep;
  endtask

  // Push one command on an idle sequencer and check latency, hold time and result.
  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [2:0] a,
                         input logic [2:0] b, input logic c, input logic si,
                         input logic dir, input logic ra, input logic rb,
                         input logic [3:0] rep, input logic [5:0] exp_out,
                         input logic exp_inv);
    int held, lat, eff;
    held = 0;
    lat  = 0;
    eff  = (rep == 0) ? 1 : int'(rep);
    @(negedge clk);
    set_cmd(op, a, b, c, si, dir, ra, rb, rep);
    bus.cmd_valid = 1'b1;
    chk({tag, "_ready"}, bus.cmd_ready, 1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (drive_nz()) held++;
      if (bus.rsp_valid) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, lat, eff + 3);
    chk({tag, "_held"}, held, eff);
    chk({tag, "_out"}, bus.rsp_out, exp_out);
    chk({tag, "_inv"}, bus.rsp_invalid, exp_inv);
    @(posedge clk);
    #1 chk({tag, "_accepted"}, bus.rsp_valid, 0);
  endtask

  logic [2:0] bp_a [6] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3};
  logic [2:0] bp_b [6] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2};
  logic       bp_c [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    int idx, extra, seen;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    set_cmd(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    #1;
    chk("rst_drive", drive_nz(), 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_out", bus.rsp_out, 0);
    chk("rst_rsp_inv", bus.rsp_invalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Idle with empty FIFO stays quiet
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_drive", drive_nz(), 0);

    run_cmd("add",   3'd2, 3'd3, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 6'd6, 1'b0);
    run_cmd("mul",   3'd3, 3'b101, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 6'b111010, 1'b0);
    run_cmd("shift", 3'd4, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 6'b000111, 1'b0);
    run_cmd("inv6",  3'd6, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 6'd0, 1'b1);
    run_cmd("invred", 3'd2, 3'd3, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 6'd0, 1'b1);

    // Backpressure: six adds back to back, sixth must be refused
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      set_cmd(3'd2, bp_a[i], bp_b[i], bp_c[i], 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      bus.cmd_valid = 1'b1;
      #1 chk($sformatf("bp_ready%0d", i), bus.cmd_ready, (i < 5) ? 1 : 0);
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1;
    end
    chk("bp_first_valid", seen, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_out%0d", k), bus.rsp_out, 6'd1);
      chk($sformatf("bp_hold_valid%0d", k), bus.rsp_valid, 1);
    end
    chk("bp_full_ready", bus.cmd_ready, 0);
    bus.rsp_ready = 1'b1;
    idx = 0;
    extra = 0;
    for (int k = 0; k < 60; k++) begin
      if (bus.rsp_valid) begin
        if (idx < 5) chk($sformatf("bp_rsp%0d", idx), bus.rsp_out, 6'(idx + 1));
        else extra++;
        idx++;
      end
      @(negedge clk);
    end
    chk("bp_rsp_count", idx, 5);
    chk("bp_extra", extra, 0);
    chk("bp_busy_done", busy, 0);

    // Reset with one command in DRIVE and three buffered
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_cmd(3'd4, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd15);
      bus.cmd_valid = 1'b1;
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_opcode", opcode, 3'd4);
    chk("mid_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("mrst_drive", drive_nz(), 0);
    chk("mrst_rsp_valid", bus.rsp_valid, 0);
    chk("mrst_ready", bus.cmd_ready, 1);
    chk("mrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.rsp_valid || drive_nz()) seen++;
    end
    chk("mrst_no_activity", seen, 0);
    chk("mrst_busy_after", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
